// File: rtl/calendar_pkg.sv
// Shared calendar constants and Gregorian helpers for the date counter.
package calendar_pkg;

    localparam logic [3:0] MONTH_MIN = 4'd1;
    localparam logic [3:0] MONTH_MAX = 4'd12;
    localparam logic [4:0] DAY_MIN   = 5'd1;

    function automatic logic is_leap(input logic [9:0] year);
        return ((year % 10'd4) == 10'd0) &&
               (((year % 10'd100) != 10'd0) || ((year % 10'd400) == 10'd0));
    endfunction

    // Out-of-range months report 31; callers validate the month separately.
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] dim;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = leap ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Combinational Gregorian leap-year flag for a 10-bit binary year.
module leap_year_detect
    import calendar_pkg::*;
(
    input  logic [9:0] year,
    output logic       leap
);

    assign leap = is_leap(year);

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year counter advanced by day_tick, with validated synchronous load
// and a one-cycle pulse on the YEAR_MAX -> 0 rollover.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_MAX   = 999,
    parameter int RESET_YEAR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       set_en,
    input  logic [9:0] set_year,
    input  logic [3:0] set_month,
    input  logic [4:0] set_day,
    output logic [9:0] year,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       leap,
    output logic       year_wrap,
    output logic       set_err
);

    localparam logic [9:0] YEAR_MAX_V   = 10'(YEAR_MAX);
    localparam logic [9:0] RESET_YEAR_V = 10'(RESET_YEAR);
    localparam logic       RESET_LEAP   = is_leap(RESET_YEAR_V);

    logic [9:0] year_reg, year_next;
    logic [3:0] month_reg, month_next;
    logic [4:0] day_reg, day_next;
    logic       leap_reg;
    logic       year_wrap_reg, year_wrap_next;
    logic       set_err_reg, set_err_next;

    logic [9:0] detect_year [2];
    logic [1:0] detect_leap;
    logic [4:0] dim_cur;
    logic       set_valid;

    // Detector 0 looks at the year about to be registered, so leap never lags year.
    assign detect_year[0] = year_next;
    assign detect_year[1] = set_year;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_leap
            leap_year_detect u_leap (
                .year (detect_year[gi]),
                .leap (detect_leap[gi])
            );
        end
    endgenerate

    assign dim_cur   = days_in_month(month_reg, leap_reg);
    assign set_valid = (set_year <= YEAR_MAX_V) &&
                       (set_month >= MONTH_MIN) && (set_month <= MONTH_MAX) &&
                       (set_day >= DAY_MIN) &&
                       (set_day <= days_in_month(set_month, detect_leap[1]));

    always_comb begin
        year_next      = year_reg;
        month_next     = month_reg;
        day_next       = day_reg;
        year_wrap_next = 1'b0;
        set_err_next   = 1'b0;
        // A load request swallows any coincident tick, accepted or not.
        if (set_en) begin
            if (set_valid) begin
                year_next  = set_year;
                month_next = set_month;
                day_next   = set_day;
            end else begin
                set_err_next = 1'b1;
            end
        end else if (day_tick) begin
            if (day_reg < dim_cur) begin
                day_next = day_reg + 5'd1;
            end else begin
                day_next = DAY_MIN;
                if (month_reg < MONTH_MAX) begin
                    month_next = month_reg + 4'd1;
                end else begin
                    month_next = MONTH_MIN;
                    if (year_reg < YEAR_MAX_V) begin
                        year_next = year_reg + 10'd1;
                    end else begin
                        year_next      = 10'd0;
                        year_wrap_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year_reg      <= RESET_YEAR_V;
            month_reg     <= MONTH_MIN;
            day_reg       <= DAY_MIN;
            leap_reg      <= RESET_LEAP;
            year_wrap_reg <= 1'b0;
            set_err_reg   <= 1'b0;
        end else begin
            year_reg      <= year_next;
            month_reg     <= month_next;
            day_reg       <= day_next;
            leap_reg      <= detect_leap[0];
            year_wrap_reg <= year_wrap_next;
            set_err_reg   <= set_err_next;
        end
    end

    assign year      = year_reg;
    assign month     = month_reg;
    assign day       = day_reg;
    assign leap      = leap_reg;
    assign year_wrap = year_wrap_reg;
    assign set_err   = set_err_reg;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Randomised and directed check of calendar_date_counter against a plain-arithmetic date model.
module tb_calendar_date_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       day_tick;
    logic       set_en;
    logic [9:0] set_year;
    logic [3:0] set_month;
    logic [4:0] set_day;
    logic [9:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic       leap;
    logic       year_wrap;
    logic       set_err;

    int total = 0;
    int bad   = 0;
    int exp_y, exp_m, exp_d;
    bit exp_wrap, exp_err;

    calendar_date_counter dut (
        .clk       (clk),
        .rst       (rst),
        .day_tick  (day_tick),
        .set_en    (set_en),
        .set_year  (set_year),
        .set_month (set_month),
        .set_day   (set_day),
        .year      (year),
        .month     (month),
        .day       (day),
        .leap      (leap),
        .year_wrap (year_wrap),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int m_dim(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && m_leap(y)) return 29;
        return tbl[m-1];
    endfunction

    task automatic model_reset();
        exp_y = 0; exp_m = 1; exp_d = 1; exp_wrap = 0; exp_err = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input int sy, input int sm, input int sd);
        exp_wrap = 0;
        exp_err  = 0;
        if (s) begin
            if (sy <= 999 && sm >= 1 && sm <= 12 && sd >= 1 && sd <= m_dim(sm, sy)) begin
                exp_y = sy; exp_m = sm; exp_d = sd;
            end else begin
                exp_err = 1;
            end
        end else if (t) begin
            exp_d++;
            if (exp_d > m_dim(exp_m, exp_y)) begin
                exp_d = 1;
                exp_m++;
                if (exp_m > 12) begin
                    exp_m = 1;
                    exp_y++;
                    if (exp_y > 999) begin
                        exp_y = 0;
                        exp_wrap = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_one(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d (model date %0d-%0d-%0d)", tag, got, want, exp_y, exp_m, exp_d);
        end
    endtask

    task automatic check_all(input string tag);
        check_one({tag, ".year"},  int'(year),      exp_y);
        check_one({tag, ".month"}, int'(month),     exp_m);
        check_one({tag, ".day"},   int'(day),       exp_d);
        check_one({tag, ".leap"},  int'(leap),      int'(m_leap(exp_y)));
        check_one({tag, ".wrap"},  int'(year_wrap), int'(exp_wrap));
        check_one({tag, ".err"},   int'(set_err),   int'(exp_err));
    endtask

    // One clock: drive, sample edge, update model, check 1 time unit after the edge.
    task automatic cycle(input string tag, input bit t, input bit s, input int sy, input int sm, input int sd);
        day_tick  = t;
        set_en    = s;
        set_year  = 10'(sy);
        set_month = 4'(sm);
        set_day   = 5'(sd);
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        set_en   = 1'b0;
        model_step(t, s, sy, sm, sd);
        check_all(tag);
        $display("%s: tick=%0b set=%0b in=%0d-%0d-%0d -> %0d-%0d-%0d leap=%0b wrap=%0b err=%0b",
                 tag, t, s, sy, sm, sd, year, month, day, leap, year_wrap, set_err);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        day_tick = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst      = 1'b0;
        day_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; day_tick = 0; set_en = 0; set_year = 0; set_month = 0; set_day = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        cycle("ld4",   0, 1, 4, 2, 28);
        cycle("t4a",   1, 0, 0, 0, 0);
        check_one("feb29", int'(day), 29);
        cycle("t4b",   1, 0, 0, 0, 0);
        cycle("ld100", 0, 1, 100, 2, 28);
        cycle("t100",  1, 0, 0, 0, 0);
        check_one("y100_mar", int'(month), 3);
        cycle("ld400", 0, 1, 400, 2, 28);
        cycle("t400",  1, 0, 0, 0, 0);
        cycle("ld999", 0, 1, 999, 12, 31);
        cycle("wrap",  1, 0, 0, 0, 0);
        check_one("wrap_hi", int'(year_wrap), 1);
        cycle("idle",  0, 0, 0, 0, 0);

        cycle("bad_a", 0, 1, 5, 4, 31);
        cycle("bad_b", 0, 1, 5, 2, 29);
        cycle("bad_c", 0, 1, 5, 13, 1);
        cycle("bad_d", 0, 1, 5, 0, 10);
        cycle("bad_e", 0, 1, 1000, 1, 1);
        cycle("bad_f", 1, 1, 5, 2, 30);
        cycle("coinc", 1, 1, 7, 6, 15);
        check_one("coinc_day", int'(day), 15);

        reset_pulse("rst1");
        for (int i = 0; i < 1000; i++) cycle("b2b", 1, 0, 0, 0, 0);
        check_one("k_year",  int'(year),  2);
        check_one("k_month", int'(month), 9);
        check_one("k_day",   int'(day),   27);

        for (int i = 0; i < 400; i++) begin
            bit t, s;
            int sy, sm, sd;
            t  = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 7) == 0);
            sy = ($urandom_range(0, 3) == 0) ? $urandom_range(995, 1023) : $urandom_range(0, 999);
            sm = ($urandom_range(0, 1) == 0) ? 2 : $urandom_range(0, 15);
            sd = ($urandom_range(0, 1) == 0) ? $urandom_range(27, 31) : $urandom_range(0, 31);
            if (i == 200) reset_pulse("rst2");
            cycle("rnd", t, s, sy, sm, sd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
